// File: rtl/inert_spi_seq.sv
// Command sequencer in front of SPI_Master: powers up and initialises the inertial
// sensor, then reads six rate bytes per data-ready interrupt and publishes them atomically.
module inert_spi_seq #(
  parameter int unsigned INIT_DLY = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] SPI_data_out,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic        vld,
  output logic        init_done
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SHADOW_W = 48;
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(INIT_DLY - 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(3);
  localparam logic [IDX_W-1:0] RD_LAST   = IDX_W'(5);

  typedef enum logic [2:0] {
    PWR_DLY   = 3'd0,
    INIT_WT   = 3'd1,
    INIT_SEND = 3'd2,
    IDLE      = 3'd3,
    RD_WT     = 3'd4,
    RD_SEND   = 3'd5,
    VALID     = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     dly_cnt_q, dly_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic [SHADOW_W-1:0]  shadow_q, shadow_d;
  logic                 init_done_q, init_done_d;
  logic                 int_ff1_q, int_ff2_q, int_ff3_q;
  logic                 int_rise;
  logic                 start_rd;
  logic                 wrt_q, wrt_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 vld_q, vld_d;
  logic [15:0]          ptch_q, ptch_d;
  logic [15:0]          roll_q, roll_d;
  logic [15:0]          yaw_q, yaw_d;
  logic                 unused_hi;

  // Only the low byte of a read response carries data.
  assign unused_hi = ^SPI_data_out[15:8];

  function automatic logic [15:0] init_cmd(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    return 16'h0D02;
      3'd1:    return 16'h1053;
      3'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    return 16'hA200;
      3'd1:    return 16'hA300;
      3'd2:    return 16'hA400;
      3'd3:    return 16'hA500;
      3'd4:    return 16'hA600;
      default: return 16'hA700;
    endcase
  endfunction

  // INT is asynchronous: two flops to synchronise, a third to find the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      int_ff3_q <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      int_ff3_q <= int_ff2_q;
    end
  end

  assign int_rise = int_ff2_q & ~int_ff3_q;
  assign start_rd = int_rise | pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PWR_DLY;
    else        state_q <= state_d;
  end

  // Next-state and sequencing bookkeeping.
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    init_done_d = init_done_q;
    case (state_q)
      PWR_DLY: begin
        dly_cnt_d = dly_cnt_q + CNT_W'(1);
        if (dly_cnt_q == DLY_LAST) state_d = INIT_WT;
      end
      INIT_WT: begin
        if (done) begin
          if (idx_q < INIT_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = INIT_SEND;
          end else begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      INIT_SEND: state_d = INIT_WT;
      IDLE: begin
        if (start_rd) begin
          pending_d = 1'b0;
          state_d   = RD_WT;
        end
      end
      RD_WT: begin
        if (int_rise) pending_d = 1'b1;
        if (done) begin
          shadow_d[{idx_q, 3'b000} +: 8] = SPI_data_out[7:0];
          if (idx_q < RD_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD_SEND;
          end else begin
            idx_d   = '0;
            state_d = VALID;
          end
        end
      end
      RD_SEND: begin
        if (int_rise) pending_d = 1'b1;
        state_d = RD_WT;
      end
      VALID: begin
        if (int_rise) pending_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = PWR_DLY;
    endcase
  end

  // Output decode: wrt/cmd are launched on the transition into each *_WT/*_SEND state.
  always_comb begin
    wrt_d  = 1'b0;
    cmd_d  = cmd_q;
    vld_d  = 1'b0;
    ptch_d = ptch_q;
    roll_d = roll_q;
    yaw_d  = yaw_q;
    case (state_q)
      PWR_DLY: begin
        if (dly_cnt_q == DLY_LAST) begin
          wrt_d = 1'b1;
          cmd_d = init_cmd(IDX_W'(0));
        end
      end
      INIT_WT: begin
        if (done && (idx_q < INIT_LAST)) begin
          wrt_d = 1'b1;
          cmd_d = init_cmd(idx_q + IDX_W'(1));
        end
      end
      IDLE: begin
        if (start_rd) begin
          wrt_d = 1'b1;
          cmd_d = rd_cmd(IDX_W'(0));
        end
      end
      RD_WT: begin
        if (done && (idx_q < RD_LAST)) begin
          wrt_d = 1'b1;
          cmd_d = rd_cmd(idx_q + IDX_W'(1));
        end
      end
      VALID: begin
        vld_d  = 1'b1;
        ptch_d = shadow_q[15:0];
        roll_d = shadow_q[31:16];
        yaw_d  = shadow_q[47:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt_q   <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      init_done_q <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      vld_q       <= 1'b0;
      ptch_q      <= '0;
      roll_q      <= '0;
      yaw_q       <= '0;
    end else begin
      dly_cnt_q   <= dly_cnt_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      init_done_q <= init_done_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      vld_q       <= vld_d;
      ptch_q      <= ptch_d;
      roll_q      <= roll_d;
      yaw_q       <= yaw_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign ptch      = ptch_q;
  assign roll      = roll_q;
  assign yaw       = yaw_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq: the initial block plays the SPI_Master role
// (done 10 clk after each wrt) and checks power-up, init, reads, pending INT and reset.
module tb_inert_spi_seq;

  localparam int unsigned DLY = 64;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] SPI_data_out;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch;
  logic [15:0] roll;
  logic [15:0] yaw;
  logic        vld;
  logic        init_done;

  int err;
  int chk;
  logic [7:0]  bytes_q[$];
  logic [15:0] cmd_log[$];
  logic [15:0] exp_init[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] exp_rd[6]   = '{16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600, 16'hA700};

  inert_spi_seq #(.INIT_DLY(DLY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .INT          (INT),
    .done         (done),
    .SPI_data_out (SPI_data_out),
    .wrt          (wrt),
    .cmd          (cmd),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .vld          (vld),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Serve n SPI transactions; optionally pulse INT once during each wait.
  task automatic spi_serve(input int n, input bit tog_int);
    int cyc;
    bit bad;
    logic [15:0] c;
    logic [7:0] b;
    for (int t = 0; t < n; t++) begin
      cyc = 0;
      bad = 1'b0;
      while (wrt !== 1'b1 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk++;
      if (wrt !== 1'b1) begin
        err++;
        $display("FAIL wrt_timeout txn %0d: wrt=%b required 1", t, wrt);
        return;
      end
      c = cmd;
      cmd_log.push_back(c);
      for (int i = 0; i < 10; i++) begin
        if (tog_int) INT = (i < 2);
        @(posedge clk); #1;
        if (wrt !== 1'b0 || cmd !== c) bad = 1'b1;
      end
      if (tog_int) INT = 1'b0;
      chk++;
      if (bad) begin
        err++;
        $display("FAIL cmd_hold txn %0d: cmd=%h wrt=%b required cmd=%h wrt=0", t, cmd, wrt, c);
      end
      b = (bytes_q.size() > 0) ? bytes_q.pop_front() : 8'h00;
      done = 1'b1;
      SPI_data_out = {8'hEE, b};
      @(posedge clk); #1;
      done = 1'b0;
      SPI_data_out = 16'h0000;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    INT = 1'b0;
    done = 1'b0;
    SPI_data_out = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk++; if (wrt !== 1'b0)      begin err++; $display("FAIL rst_wrt: got %b required 0", wrt); end
    chk++; if (cmd !== 16'h0)     begin err++; $display("FAIL rst_cmd: got %h required 0000", cmd); end
    chk++; if ({ptch, roll, yaw} !== 48'h0) begin err++; $display("FAIL rst_data: got %h %h %h required 0", ptch, roll, yaw); end
    chk++; if (vld !== 1'b0)      begin err++; $display("FAIL rst_vld: got %b required 0", vld); end
    chk++; if (init_done !== 1'b0) begin err++; $display("FAIL rst_init_done: got %b required 0", init_done); end
  endtask

  // Release reset and time the first init write; a stray done mid-delay must not matter.
  task automatic test_power_up();
    int first;
    first = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 11) done = 1'b0;
      if (wrt === 1'b1) begin
        first = k;
        break;
      end
      if (k == 10) done = 1'b1;
    end
    chk++; if (first != DLY) begin err++; $display("FAIL pwr_delay: first wrt at %0d clk required %0d", first, DLY); end
    chk++; if (cmd !== 16'h0D02) begin err++; $display("FAIL pwr_cmd: got %h required 0D02", cmd); end
  endtask

  // Init writes; INT rises during init and must be discarded.
  task automatic test_init();
    int wcount;
    cmd_log.delete();
    INT = 1'b1;
    spi_serve(3, 1'b0);
    chk++; if (init_done !== 1'b0) begin err++; $display("FAIL init_done_early: got %b required 0", init_done); end
    spi_serve(1, 1'b0);
    chk++; if (init_done !== 1'b1) begin err++; $display("FAIL init_done_rise: got %b required 1", init_done); end
    chk++; if (cmd_log.size() != 4) begin err++; $display("FAIL init_count: got %0d required 4", cmd_log.size()); end
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      chk++;
      if (cmd_log[i] !== exp_init[i]) begin err++; $display("FAIL init_cmd%0d: got %h required %h", i, cmd_log[i], exp_init[i]); end
    end
    wcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) INT = 1'b0;
      @(posedge clk); #1;
      if (wrt === 1'b1) wcount++;
    end
    chk++; if (wcount != 0) begin err++; $display("FAIL init_int_ignored: got %0d wrts required 0", wcount); end
  endtask

  task automatic test_spurious_done();
    int wcount;
    logic [15:0] p0;
    p0 = ptch;
    wcount = 0;
    done = 1'b1;
    SPI_data_out = 16'h00FF;
    @(posedge clk); #1;
    done = 1'b0;
    SPI_data_out = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (wrt === 1'b1 || vld === 1'b1) wcount++;
    end
    chk++; if (wcount != 0 || ptch !== p0) begin err++; $display("FAIL idle_spurious_done: events=%0d ptch=%h required 0 events ptch=%h", wcount, ptch, p0); end
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    INT = 1'b0;
  endtask

  task automatic test_read();
    cmd_log.delete();
    bytes_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    pulse_int();
    spi_serve(3, 1'b0);
    chk++; if (ptch !== 16'h0 || vld !== 1'b0) begin err++; $display("FAIL rd_partial: ptch=%h vld=%b required 0000 0", ptch, vld); end
    spi_serve(3, 1'b0);
    chk++; if (vld !== 1'b0 || ptch !== 16'h0) begin err++; $display("FAIL rd_pre_vld: vld=%b ptch=%h required 0 0000", vld, ptch); end
    @(posedge clk); #1;
    chk++; if (vld !== 1'b1) begin err++; $display("FAIL rd_vld: got %b required 1", vld); end
    chk++; if ({ptch, roll, yaw} !== {16'h1234, 16'h5678, 16'h9ABC}) begin err++; $display("FAIL rd_data: got %h %h %h required 1234 5678 9ABC", ptch, roll, yaw); end
    @(posedge clk); #1;
    chk++; if (vld !== 1'b0) begin err++; $display("FAIL rd_vld_pulse: got %b required 0", vld); end
    chk++; if (cmd_log.size() != 6) begin err++; $display("FAIL rd_count: got %0d required 6", cmd_log.size()); end
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
      chk++;
      if (cmd_log[i] !== exp_rd[i]) begin err++; $display("FAIL rd_cmd%0d: got %h required %h", i, cmd_log[i], exp_rd[i]); end
    end
  endtask

  // Three INT edges during a read collapse into exactly one follow-up sequence.
  task automatic test_back_to_back();
    int wcount;
    cmd_log.delete();
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pulse_int();
    spi_serve(1, 1'b0);
    spi_serve(3, 1'b1);
    spi_serve(2, 1'b0);
    @(posedge clk); #1;
    chk++; if (vld !== 1'b1 || {ptch, roll, yaw} !== {16'h2211, 16'h4433, 16'h6655}) begin
      err++; $display("FAIL b2b_first: vld=%b data=%h %h %h required 1 2211 4433 6655", vld, ptch, roll, yaw);
    end
    @(posedge clk); #1;
    spi_serve(6, 1'b0);
    @(posedge clk); #1;
    chk++; if (vld !== 1'b1 || {ptch, roll, yaw} !== {16'h0201, 16'h0403, 16'h0605}) begin
      err++; $display("FAIL b2b_second: vld=%b data=%h %h %h required 1 0201 0403 0605", vld, ptch, roll, yaw);
    end
    wcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wrt === 1'b1) wcount++;
    end
    chk++; if (wcount != 0) begin err++; $display("FAIL b2b_extra_seq: got %0d wrts required 0", wcount); end
    chk++; if (cmd_log.size() != 12) begin err++; $display("FAIL b2b_count: got %0d required 12", cmd_log.size()); end
  endtask

  task automatic test_reset_mid_read();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC};
    pulse_int();
    spi_serve(3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk++; if (wrt !== 1'b0 || vld !== 1'b0) begin err++; $display("FAIL mid_rst_ctl: wrt=%b vld=%b required 0 0", wrt, vld); end
    chk++; if ({ptch, roll, yaw} !== 48'h0 || cmd !== 16'h0) begin err++; $display("FAIL mid_rst_data: %h %h %h cmd=%h required 0", ptch, roll, yaw, cmd); end
    chk++; if (init_done !== 1'b0) begin err++; $display("FAIL mid_rst_init_done: got %b required 0", init_done); end
    repeat (3) @(posedge clk);
    test_power_up();
    test_init();
    chk++; if (ptch !== 16'h0 || vld !== 1'b0) begin err++; $display("FAIL mid_rst_post: ptch=%h vld=%b required 0000 0", ptch, vld); end
  endtask

  initial begin
    err = 0;
    chk = 0;
    test_reset();
    test_power_up();
    test_init();
    test_spurious_done();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
